// File: rtl/mc_trace_intake.sv
// Trace intake: requests packed {time, cmd, addr} entries, buffers them, and
// releases the head entry on a valid/ready port. Define MC_TRACE_TIME_GATE_EN to hold release until cycle >= time.

// state | meaning
// IDLE  | decide whether to request another entry
// WAIT  | request outstanding, timer running toward end-of-trace
// DONE  | trace exhausted or shut down; FIFO keeps draining until reset
module mc_trace_intake #(
   parameter int ADDR_WIDTH  = 36,
   parameter int MEMOP_WIDTH = 2,
   parameter int TIME_WIDTH  = 12,
   parameter int DEPTH       = 8,
   parameter int TIMEOUT     = 16
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [63:0]                               cycle,
   output logic                                      data_req,
   input  logic                                      data_rdy,
   input  logic [TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH-1:0] data_read,
   input  logic                                      shutdown,
   output logic                                      req_valid,
   input  logic                                      req_ready,
   output logic [TIME_WIDTH-1:0]                     req_time,
   output logic [MEMOP_WIDTH-1:0]                    req_cmd,
   output logic [ADDR_WIDTH-1:0]                     req_addr,
   output logic [$clog2(DEPTH):0]                    count,
   output logic                                      trace_done,
   output logic                                      overflow,
   output logic                                      spurious
);

   localparam int DW = TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            data_req_q, data_req_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            enq;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            overflow_q, spurious_q;
   logic [DW-1:0]   mem [DEPTH];
   logic            full, empty, wr_en, deq, due;

   always_comb begin
      state_d    = state_q;
      data_req_d = 1'b0;
      timer_d    = timer_q;
      enq        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (shutdown) begin
               state_d = S_DONE;
            end else if (count_q < COUNT_FULL) begin
               data_req_d = 1'b1;
               timer_d    = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (data_rdy) begin
               enq     = 1'b1;
               state_d = S_IDLE;
            end else if (shutdown) begin
               state_d = S_DONE;
            end else if (timer_q == TIMER_LAST) begin
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         data_req_q <= 1'b0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         data_req_q <= data_req_d;
         timer_q    <= timer_d;
      end
   end

   assign full  = (count_q == COUNT_FULL);
   assign empty = (count_q == '0);
   assign wr_en = enq && !full;

`ifdef MC_TRACE_TIME_GATE_EN
   assign due = ({{(64-TIME_WIDTH){1'b0}}, req_time} <= cycle);
`else
   logic unused_cycle;
   assign unused_cycle = ^cycle;
   assign due = 1'b1;
`endif

   assign req_valid = !empty && due;
   assign deq       = req_valid && req_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (deq)   rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({wr_en, deq})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (enq && full) overflow_q <= 1'b1;
         if (data_rdy && (state_q != S_WAIT)) spurious_q <= 1'b1;
      end
   end

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (wr_en && !reset) mem[wr_ptr_q] <= data_read;
   end

   assign {req_time, req_cmd, req_addr} = mem[rd_ptr_q];

   assign data_req   = data_req_q;
   assign count      = count_q;
   assign trace_done = (state_q == S_DONE);
   assign overflow   = overflow_q;
   assign spurious   = spurious_q;

endmodule

// File: tb/tb_mc_trace_intake.sv
// Directed bench for mc_trace_intake; expectations follow MC_TRACE_TIME_GATE_EN.
module tb_mc_trace_intake;

   localparam int AW = 36;
   localparam int MW = 2;
   localparam int TMW = 12;
   localparam int DW = TMW + MW + AW;

   logic          clock = 1'b0;
   logic          reset;
   logic [63:0]   cycle;
   logic          data_req;
   logic          data_rdy;
   logic [DW-1:0] data_read;
   logic          shutdown;
   logic          req_valid;
   logic          req_ready;
   logic [TMW-1:0] req_time;
   logic [MW-1:0] req_cmd;
   logic [AW-1:0] req_addr;
   logic [3:0]    count;
   logic          trace_done;
   logic          overflow;
   logic          spurious;

   int n_cmp = 0;
   int n_fail = 0;

   mc_trace_intake dut (
      .clock(clock), .reset(reset), .cycle(cycle), .data_req(data_req),
      .data_rdy(data_rdy), .data_read(data_read), .shutdown(shutdown),
      .req_valid(req_valid), .req_ready(req_ready), .req_time(req_time),
      .req_cmd(req_cmd), .req_addr(req_addr), .count(count),
      .trace_done(trace_done), .overflow(overflow), .spurious(spurious)
   );

   always #5 clock = ~clock;

   task automatic do_reset();
      reset = 1'b1; cycle = '0; data_rdy = 1'b0; data_read = '0;
      shutdown = 1'b0; req_ready = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic wait_req(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (data_req === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s wait_data_req: data_req=%b required=1 within 40 cycles", name, data_req);
      end
   endtask

   // Answers the request seen at this negedge; next edge captures the word.
   task automatic respond(input logic [DW-1:0] w, input logic sd);
      data_rdy = 1'b1; data_read = w; shutdown = sd;
      @(negedge clock);
      data_rdy = 1'b0;
   endtask

   task automatic count_req_pulses(input int ncyc, output int pulses);
      pulses = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clock);
         if (data_req === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cycle = '0; data_rdy = 1'b1; data_read = '1;
      shutdown = 1'b0; req_ready = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({data_req, req_valid, count, trace_done, overflow, spurious} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b valid=%b count=%0d done=%b ovf=%b spur=%b required all 0",
                  data_req, req_valid, count, trace_done, overflow, spurious);
      end
      data_rdy = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (data_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_req: data_req=%b required=1", data_req);
      end
      n_cmp++;
      if (spurious !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_spurious: spurious=%b required=0", spurious);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] w;
      w = {12'd5, 2'd2, 36'h0_1234_5678};
      do_reset();
      wait_req("basic");
      respond(w, 1'b0);
      n_cmp++;
      if (count !== 4'd1) begin
         n_fail++;
         $display("FAIL basic_count: count=%0d required=1", count);
      end
`ifdef MC_TRACE_TIME_GATE_EN
      n_cmp++;
      if (req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_not_due_0: req_valid=%b required=0", req_valid);
      end
      cycle = 64'd4;
      #1;
      n_cmp++;
      if (req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_not_due_4: req_valid=%b required=0", req_valid);
      end
      cycle = 64'd5;
      #1;
`endif
      n_cmp++;
      if (req_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_valid: req_valid=%b required=1", req_valid);
      end
      n_cmp++;
      if ({req_time, req_cmd, req_addr} !== w) begin
         n_fail++;
         $display("FAIL basic_fields: got=%h required=%h", {req_time, req_cmd, req_addr}, w);
      end
      req_ready = 1'b1;
      @(negedge clock);
      req_ready = 1'b0;
      n_cmp++;
      if (count !== 4'd0) begin
         n_fail++;
         $display("FAIL basic_drain: count=%0d required=0", count);
      end
   endtask

   task automatic test_fill();
      int pulses;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         wait_req("fill");
         respond({12'd0, 2'(i), 36'(36'h0_B000_0000 + i)}, 1'b0);
      end
      n_cmp++;
      if (count !== 4'd8) begin
         n_fail++;
         $display("FAIL fill_count: count=%0d required=8", count);
      end
      count_req_pulses(10, pulses);
      n_cmp++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL fill_no_req: pulses=%0d required=0", pulses);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_overflow: overflow=%b required=0", overflow);
      end
      n_cmp++;
      if (req_addr !== 36'h0_B000_0000) begin
         n_fail++;
         $display("FAIL fill_head: addr=%h required=%h", req_addr, 36'h0_B000_0000);
      end
      req_ready = 1'b1;
      @(negedge clock);
      req_ready = 1'b0;
      n_cmp++;
      if (count !== 4'd7) begin
         n_fail++;
         $display("FAIL fill_deq_count: count=%0d required=7", count);
      end
      count_req_pulses(10, pulses);
      n_cmp++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL fill_one_req: pulses=%0d required=1", pulses);
      end
   endtask

   task automatic test_timeout();
      int pulses;
      do_reset();
      wait_req("timeout");
      repeat (15) @(negedge clock);
      n_cmp++;
      if (trace_done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: trace_done=%b required=0", trace_done);
      end
      @(negedge clock);
      n_cmp++;
      if (trace_done !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_done: trace_done=%b required=1", trace_done);
      end
      count_req_pulses(20, pulses);
      n_cmp++;
      if (pulses != 0 || trace_done !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_quiet: pulses=%0d done=%b required 0 and 1", pulses, trace_done);
      end
   endtask

   task automatic test_shutdown();
      int pulses;
      do_reset();
      wait_req("shutdown");
      respond({12'd0, 2'd1, 36'h0_0000_0ABC}, 1'b1);
      n_cmp++;
      if (count !== 4'd1 || trace_done !== 1'b0) begin
         n_fail++;
         $display("FAIL shutdown_enq: count=%0d done=%b required 1 and 0", count, trace_done);
      end
      @(negedge clock);
      n_cmp++;
      if (trace_done !== 1'b1) begin
         n_fail++;
         $display("FAIL shutdown_done: trace_done=%b required=1", trace_done);
      end
      count_req_pulses(10, pulses);
      n_cmp++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL shutdown_no_req: pulses=%0d required=0", pulses);
      end
   endtask

   task automatic test_spurious_wrap();
      logic [AW-1:0] exp_q[$];
      int sent;
      int got;
      do_reset();
      req_ready = 1'b0;
      wait_req("wrap");
      // Entry 0, then data_rdy again while the FSM sits in IDLE.
      data_rdy = 1'b1; data_read = {12'd0, 2'd0, 36'h0_A000_0000};
      exp_q.push_back(36'h0_A000_0000);
      @(negedge clock);
      data_read = {12'd0, 2'd3, 36'h0_DEAD_0000};
      @(negedge clock);
      data_rdy = 1'b0;
      n_cmp++;
      if (spurious !== 1'b1 || count !== 4'd1) begin
         n_fail++;
         $display("FAIL spurious_set: spurious=%b count=%0d required 1 and 1", spurious, count);
      end
      sent = 1;
      got = 0;
      req_ready = 1'b1;
      for (int i = 0; i < 300 && got < 20; i++) begin
         if (req_valid === 1'b1) begin
            n_cmp++;
            if (req_addr !== exp_q[0]) begin
               n_fail++;
               $display("FAIL wrap_order[%0d]: addr=%h required=%h", got, req_addr, exp_q[0]);
            end
            void'(exp_q.pop_front());
            got++;
         end
         if (data_req === 1'b1 && sent < 20) begin
            data_rdy = 1'b1;
            data_read = {12'd0, 2'(sent), 36'(36'h0_A000_0000 + sent)};
            exp_q.push_back(36'(36'h0_A000_0000 + sent));
            sent++;
         end else begin
            data_rdy = 1'b0;
         end
         @(negedge clock);
      end
      data_rdy = 1'b0;
      req_ready = 1'b0;
      n_cmp++;
      if (got != 20 || count !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_final: dequeued=%0d count=%0d required 20 and 0", got, count);
      end
      n_cmp++;
      if (spurious !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_flags: spurious=%b overflow=%b required 1 and 0", spurious, overflow);
      end
   endtask

   task automatic test_untimed();
      logic exp_v;
      do_reset();
      wait_req("untimed");
      respond({12'd4000, 2'd1, 36'h0_0000_4000}, 1'b0);
`ifdef MC_TRACE_TIME_GATE_EN
      exp_v = 1'b0;
`else
      exp_v = 1'b1;
`endif
      n_cmp++;
      if (req_valid !== exp_v || req_time !== 12'd4000) begin
         n_fail++;
         $display("FAIL untimed_valid: valid=%b time=%0d required %b and 4000", req_valid, req_time, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_timeout();
      test_shutdown();
      test_spurious_wrap();
      test_untimed();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_trace_intake.md
# mc_trace_intake

Consumer end of the parser→memory-controller trace handshake. Requests trace entries with `data_req`, captures the packed `{time, cmd, addr}` word on `data_rdy`, and buffers entries in a FIFO. The head entry is released on a valid/ready port to the controller's scheduling logic once the running `cycle` count reaches the entry's timestamp. The block also detects end-of-trace by timeout and honours `shutdown`.

## Interface
Parameters:
- `ADDR_WIDTH`, 36: address field width.
- `MEMOP_WIDTH`, 2: memory-op command field width.
- `TIME_WIDTH`, 12: timestamp field width.
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `TIMEOUT`, 16: cycles in WAIT with no `data_rdy` before the trace is declared exhausted; at least 2.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cycle` in 64: running cycle count, treated as unsigned.
- `data_req` out 1: one-cycle pulse requesting the next trace entry.
- `data_rdy` in 1: `data_read` is valid when this is sampled high.
- `data_read` in TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH: packed word `{time, cmd, addr}`, with time at the MSBs.
- `shutdown` in 1: stop requesting new entries.
- `req_valid` out 1: head entry is eligible for issue.
- `req_ready` in 1: consumer accepts the head entry.
- `req_time` out TIME_WIDTH, `req_cmd` out MEMOP_WIDTH, `req_addr` out ADDR_WIDTH: head entry fields.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `trace_done` out 1: sticky; no further entries will be requested.
- `overflow` out 1: sticky; an entry was dropped because the FIFO was full.
- `spurious` out 1: sticky; `data_rdy` was sampled high outside WAIT.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If `shutdown` is high → DONE.
  - Else if `count < DEPTH` → register `data_req=1` for one cycle, clear the timer, go to WAIT.
  - Else stay in IDLE.
- WAIT:
  - If `data_rdy` is high → enqueue `data_read` (drop it and set `overflow` if full), go to IDLE.
  - Else if `shutdown` is high → DONE.
  - Else if `timer == TIMEOUT-1` → DONE.
  - Else increment the timer.
- DONE: terminal until `reset`. `trace_done=1`. The FIFO keeps draining.
- `data_rdy` sampled high in IDLE or DONE: data is discarded and `spurious` is set.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - `count` is maintained separately. Simultaneous enqueue and dequeue leaves `count` unchanged.
- Release: the head is "due" when the zero-extended `req_time` is ≤ `cycle` (64-bit unsigned compare).
- `req_valid = !empty && due`. See Configuration for the no-gating build.
- Dequeue when `req_valid && req_ready`.
- `req_*` are driven combinationally from the head entry. Their value when `count==0` is don't-care.

## Timing
- Reset values: `data_req=0`, `req_valid=0`, `count=0`, `trace_done=0`, `overflow=0`, `spurious=0`, FSM=IDLE, pointers=0, timer=0.
- `data_req` rises the cycle after the IDLE evaluation and is high for exactly one cycle.
- `data_rdy` is accepted from the edge after `data_req` rises through TIMEOUT edges.
- Peak intake is one entry per 2 cycles (IDLE→WAIT→IDLE).
- Enqueue → `req_valid` latency:
  - 1 cycle if the FIFO was empty and the entry is already due.
  - Otherwise `req_valid` rises the cycle `cycle` reaches the timestamp.
- Only one request is outstanding at a time. The full check happens in IDLE, so overflow occurs only if the consumer violates the protocol.
- `data_rdy` and `shutdown` in the same WAIT cycle: the entry is enqueued and the FSM goes to IDLE, then to DONE on the next cycle. No further `data_req`.
- `reset` mid-WAIT: the outstanding request is abandoned and the FIFO is flushed. Any `data_rdy` in the reset cycle is ignored and does not set `spurious`.
- Dequeue with `req_ready` high while `req_valid` is low: no effect.

## Configuration
- `MC_TRACE_TIME_GATE_EN` defined: release is time-gated as described in Operation.
- `MC_TRACE_TIME_GATE_EN` undefined:
  - `req_valid = !empty`, and `cycle` is unused.
  - Timestamps pass through on `req_time` only.
  - All other behaviour is identical.

## Test plan
- **Basic intake:** after reset, respond to `data_req` with `data_rdy` and word time=5, cmd=2, addr=0x0_1234_5678, with `cycle`=0. Required: `req_valid` stays 0 until `cycle`=5, then `req_valid=1` with matching fields; pulsing `req_ready` gives `count`=0.
- **Fill to DEPTH=8:** answer every request, hold `req_ready=0`, all timestamps 0. Required: `count` reaches 8, `data_req` stays 0 afterwards, `overflow=0`. One dequeue then produces exactly one new `data_req`.
- **Timeout:** never assert `data_rdy`. Required: with TIMEOUT=16, `trace_done=1` 16 cycles after WAIT entry, and `data_req` never pulses again.
- **Shutdown:** assert `shutdown` in the same WAIT cycle as `data_rdy`. Required: the entry is enqueued (`count`+1), FSM reaches DONE one cycle later, no further `data_req`.
- **Spurious and wrap-around:** pulse `data_rdy` while in IDLE, then stream 20 entries with concurrent dequeues. Required: `spurious=1`, FIFO order preserved across pointer wrap, final `count`=0.
- **Untimed build:** build with `MC_TRACE_TIME_GATE_EN` undefined, time=4000, `cycle`=0. Required: `req_valid=1` one cycle after enqueue.
